// File: rtl/draw_request_arbiter.sv
// rtl/draw_request_arbiter.sv - round-robin arbiter sharing one object-drawing engine among four requesters
module draw_request_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req_start,
  input  logic [35:0] req_x,
  input  logic [31:0] req_y,
  input  logic [19:0] req_type,
  input  logic [19:0] req_length,
  input  logic [19:0] req_height,
  output logic [3:0]  req_done,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        draw_start,
  output logic [8:0]  draw_x,
  output logic [7:0]  draw_y,
  output logic [4:0]  draw_type,
  output logic [4:0]  draw_length,
  output logic [4:0]  draw_height,
  input  logic        draw_object_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_DRAW    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_g;
  logic [1:0]  w_sel;
  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [4:0]  r_type;
  logic [4:0]  r_length;
  logic [4:0]  r_height;

  // Scan from the far end so the requester closest to r_ptr overwrites last and wins.
  always_comb begin
    w_sel = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req_start[r_ptr + 2'(i)]) begin
        w_sel = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|req_start) w_state_nxt = ST_LATCH;
      ST_LATCH:   w_state_nxt = ST_DRAW;
      ST_DRAW:    if (draw_object_done) w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!req_start[r_g]) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd0;
      r_g      <= 2'd0;
      r_x      <= '0;
      r_y      <= '0;
      r_type   <= '0;
      r_length <= '0;
      r_height <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && |req_start) begin
        r_g <= w_sel;
      end
      if (r_state == ST_LATCH) begin
        r_x      <= req_x[9*r_g +: 9];
        r_y      <= req_y[8*r_g +: 8];
        r_type   <= req_type[5*r_g +: 5];
        r_length <= req_length[5*r_g +: 5];
        r_height <= req_height[5*r_g +: 5];
      end
      if (r_state == ST_RELEASE && !req_start[r_g]) begin
        r_ptr <= r_g + 2'd1;
      end
    end
  end

  // Everything below decodes from registered state only; no req_* path reaches the engine.
  always_comb begin
    busy       = (r_state != ST_IDLE);
    draw_start = (r_state == ST_DRAW);
    grant      = (r_state != ST_IDLE) ? (4'b0001 << r_g) : 4'b0000;
    req_done   = (r_state == ST_RELEASE) ? (4'b0001 << r_g) : 4'b0000;
  end

  assign draw_x      = r_x;
  assign draw_y      = r_y;
  assign draw_type   = r_type;
  assign draw_length = r_length;
  assign draw_height = r_height;

endmodule
